// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
//
// Purpose:
//   Four-channel DMA request arbiter. Raw DREQ lines are polarity-corrected
//   and registered once. They are then combined with the mask register and the
//   software request register to form the effective request vector. A small
//   FSM (IDLE -> GRANTED -> RELEASE -> IDLE) picks one winner and holds the
//   grant until timing control pulses svcDone. It then spends exactly one
//   cycle with every grant output low before it arbitrates again.
//
//   Priority is fixed (channel 0 highest) by default. When the macro
//   DMA_ROTATING_PRIORITY_EN is defined, a rotation pointer register is built.
//   In that build, rotatingPri = 1 makes channel ptr the highest priority, and
//   each completed service moves ptr to grantChan + 1.
//
// Handshake:
//   A grant is a level, not a pulse. grantValid and exactly one VALID_DREQn
//   rise together and stay high until the cycle after svcDone is sampled high
//   in GRANTED. svcDone (with an optional tcPulse) is a single-cycle strobe
//   and is ignored in any other state.
//
// Ports:
//   CLK, RESET                    clock, asynchronous active-high reset
//   DREQ[3:0], dreqActiveLow      raw channel requests and their polarity
//   rotatingPri                   1 = rotating priority (rotation build only)
//   ctrlDisable                   1 = no new grants from IDLE
//   maskWr / maskData             write all four mask bits
//   maskSingleWr / maskSingleData {set, chan[1:0]} set/clear one mask bit
//   swReqWr / swReqData           {set, chan[1:0]} set/clear one software request
//   svcDone, tcPulse              end of service, terminal count
//   autoInit[3:0]                 per-channel autoinitialize (no auto-mask on TC)
//   VALID_DREQ0..3                one-hot grant to timing control
//   grantChan, grantValid         encoded grant
//   maskReg, reqReg, reqStatus    mask, software requests, pending requests
//   dbgState                      current FSM state (0 IDLE, 1 GRANTED, 2 RELEASE)
//
// Configuration macro: DMA_ROTATING_PRIORITY_EN

module dma_priority_arbiter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic       dreqActiveLow,
    input  logic       rotatingPri,
    input  logic       ctrlDisable,
    input  logic       maskWr,
    input  logic [3:0] maskData,
    input  logic       maskSingleWr,
    input  logic [2:0] maskSingleData,
    input  logic       swReqWr,
    input  logic [2:0] swReqData,
    input  logic       svcDone,
    input  logic       tcPulse,
    input  logic [3:0] autoInit,
    output logic       VALID_DREQ0,
    output logic       VALID_DREQ1,
    output logic       VALID_DREQ2,
    output logic       VALID_DREQ3,
    output logic [1:0] grantChan,
    output logic       grantValid,
    output logic [3:0] maskReg,
    output logic [3:0] reqReg,
    output logic [3:0] reqStatus,
    output logic [1:0] dbgState
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        RELEASE = 2'd2
    } arbState_t;

    arbState_t  state;
    logic [3:0] dreqSync;
    logic [3:0] grantOneHot;
    logic [3:0] effReq;
    logic [1:0] priStart;
    logic [1:0] winner;
    logic       anyReq;
    logic       svcHit;
    logic       tcHit;
    logic [3:0] maskNext;
    logic [3:0] reqNext;

    // ------------------------------------------------------------------
    // Request sampling and status
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dreqSync <= 4'h0;
        end else begin
            dreqSync <= dreqActiveLow ? ~DREQ : DREQ;
        end
    end

    // Software requests bypass the mask on purpose: the CPU asked for the
    // transfer explicitly.
    assign effReq    = (dreqSync & ~maskReg) | reqReg;
    assign anyReq    = |effReq;
    assign reqStatus = dreqSync | reqReg;

    // ------------------------------------------------------------------
    // Priority start point
    // ------------------------------------------------------------------
`ifdef DMA_ROTATING_PRIORITY_EN
    logic [1:0] ptr;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr <= 2'd0;
        end else if (svcHit) begin
            ptr <= grantChan + 2'd1;
        end
    end

    assign priStart = rotatingPri ? ptr : 2'd0;
`else
    // Fixed priority only. rotatingPri is accepted on the port but has no
    // effect in this build.
    logic unusedRotatingPri;
    assign unusedRotatingPri = rotatingPri;
    assign priStart          = 2'd0;
`endif

    // Walk from lowest to highest priority so that the last match, which is
    // the highest-priority pending channel, is the one that sticks.
    always_comb begin
        logic [1:0] idx;
        winner = 2'd0;
        idx    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = priStart + 2'(i);
            if (effReq[idx]) begin
                winner = idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mask and software request registers
    // ------------------------------------------------------------------
    assign svcHit = (state == GRANTED) && svcDone;
    assign tcHit  = svcHit && tcPulse;

    // Apply the terminal-count update first, then the CPU writes. Any CPU
    // write therefore overrides a TC update to the same bit. The single-bit
    // mask write comes after the write-all so that it lands on top.
    always_comb begin
        maskNext = maskReg;
        if (tcHit && !autoInit[grantChan]) begin
            maskNext[grantChan] = 1'b1;
        end
        if (maskWr) begin
            maskNext = maskData;
        end
        if (maskSingleWr) begin
            maskNext[maskSingleData[1:0]] = maskSingleData[2];
        end
    end

    always_comb begin
        reqNext = reqReg;
        if (tcHit) begin
            reqNext[grantChan] = 1'b0;
        end
        if (swReqWr) begin
            reqNext[swReqData[1:0]] = swReqData[2];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            maskReg <= 4'hF;
            reqReg  <= 4'h0;
        end else begin
            maskReg <= maskNext;
            reqReg  <= reqNext;
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM with registered grant outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            grantValid  <= 1'b0;
            grantChan   <= 2'd0;
            grantOneHot <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (!ctrlDisable && anyReq) begin
                        state       <= GRANTED;
                        grantValid  <= 1'b1;
                        grantChan   <= winner;
                        grantOneHot <= 4'b0001 << winner;
                    end
                end
                GRANTED: begin
                    // The grant is held against every input except svcDone.
                    if (svcDone) begin
                        state       <= RELEASE;
                        grantValid  <= 1'b0;
                        grantChan   <= 2'd0;
                        grantOneHot <= 4'h0;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    grantValid  <= 1'b0;
                    grantChan   <= 2'd0;
                    grantOneHot <= 4'h0;
                end
            endcase
        end
    end

    assign VALID_DREQ0 = grantOneHot[0];
    assign VALID_DREQ1 = grantOneHot[1];
    assign VALID_DREQ2 = grantOneHot[2];
    assign VALID_DREQ3 = grantOneHot[3];
    assign dbgState    = state;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed testbench for dma_priority_arbiter.
// Inputs are driven on the falling clock edge, and outputs are sampled on the
// same falling edge, half a cycle after the rising edge that updated them.

module tb_dma_priority_arbiter;

    logic       CLK;
    logic       RESET;
    logic [3:0] DREQ;
    logic       dreqActiveLow;
    logic       rotatingPri;
    logic       ctrlDisable;
    logic       maskWr;
    logic [3:0] maskData;
    logic       maskSingleWr;
    logic [2:0] maskSingleData;
    logic       swReqWr;
    logic [2:0] swReqData;
    logic       svcDone;
    logic       tcPulse;
    logic [3:0] autoInit;
    logic       VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3;
    logic [1:0] grantChan;
    logic       grantValid;
    logic [3:0] maskReg;
    logic [3:0] reqReg;
    logic [3:0] reqStatus;
    logic [1:0] dbgState;

    int checks = 0;
    int errors = 0;

    dma_priority_arbiter dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .DREQ          (DREQ),
        .dreqActiveLow (dreqActiveLow),
        .rotatingPri   (rotatingPri),
        .ctrlDisable   (ctrlDisable),
        .maskWr        (maskWr),
        .maskData      (maskData),
        .maskSingleWr  (maskSingleWr),
        .maskSingleData(maskSingleData),
        .swReqWr       (swReqWr),
        .swReqData     (swReqData),
        .svcDone       (svcDone),
        .tcPulse       (tcPulse),
        .autoInit      (autoInit),
        .VALID_DREQ0   (VALID_DREQ0),
        .VALID_DREQ1   (VALID_DREQ1),
        .VALID_DREQ2   (VALID_DREQ2),
        .VALID_DREQ3   (VALID_DREQ3),
        .grantChan     (grantChan),
        .grantValid    (grantValid),
        .maskReg       (maskReg),
        .reqReg        (reqReg),
        .reqStatus     (reqStatus),
        .dbgState      (dbgState)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [7:0] validVec();
        return {4'h0, VALID_DREQ3, VALID_DREQ2, VALID_DREQ1, VALID_DREQ0};
    endfunction

    task automatic checkGrant(input string tag, input logic [1:0] ch);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        chk({tag, "_gv"},  {7'h0, grantValid}, 8'h01);
        chk({tag, "_ch"},  {6'h0, grantChan}, {6'h0, ch});
        chk({tag, "_oh"},  validVec(), {4'h0, oh});
    endtask

    task automatic checkIdleOutputs(input string tag);
        chk({tag, "_gv"}, {7'h0, grantValid}, 8'h00);
        chk({tag, "_oh"}, validVec(), 8'h00);
    endtask

    task automatic defaults();
        DREQ           = 4'h0;
        dreqActiveLow  = 1'b0;
        rotatingPri    = 1'b0;
        ctrlDisable    = 1'b0;
        maskWr         = 1'b0;
        maskData       = 4'h0;
        maskSingleWr   = 1'b0;
        maskSingleData = 3'h0;
        swReqWr        = 1'b0;
        swReqData      = 3'h0;
        svcDone        = 1'b0;
        tcPulse        = 1'b0;
        autoInit       = 4'h0;
    endtask

    // Assert reset between clock edges, check the asynchronous clear, and
    // release it on the following falling edge.
    task automatic doReset(input string tag);
        RESET = 1'b1;
        #1;
        chk({tag, "_oh"},   validVec(), 8'h00);
        chk({tag, "_gv"},   {7'h0, grantValid}, 8'h00);
        chk({tag, "_ch"},   {6'h0, grantChan}, 8'h00);
        chk({tag, "_mask"}, {4'h0, maskReg}, 8'h0F);
        chk({tag, "_req"},  {4'h0, reqReg}, 8'h00);
        chk({tag, "_st"},   {6'h0, dbgState}, 8'h00);
        defaults();
        cyc(1);
        RESET = 1'b0;
    endtask

    task automatic doSvc(input logic tc);
        svcDone = 1'b1;
        tcPulse = tc;
        cyc(1);
        svcDone = 1'b0;
        tcPulse = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic [1:0] rotExp [5];

    initial begin
        RESET = 1'b1;
        defaults();
        cyc(2);

        // Reset values and the basic fixed-priority grant
        doReset("rst0");
        maskWr = 1'b1; maskData = 4'h0; DREQ = 4'b1010;
        cyc(1);
        maskWr = 1'b0;
        checkIdleOutputs("lat1");
        cyc(1);
        checkGrant("fix_ch1", 2'd1);
        chk("fix_status", {4'h0, reqStatus}, 8'h0A);
        chk("fix_state",  {6'h0, dbgState}, 8'h01);

        // Grant held against DREQ drop, higher-priority arrival, and ctrlDisable
        DREQ = 4'b0001; ctrlDisable = 1'b1;
        cyc(2);
        checkGrant("hold_ch1", 2'd1);
        ctrlDisable = 1'b0; DREQ = 4'b1000;
        doSvc(1'b0);
        checkIdleOutputs("rel");
        chk("rel_state", {6'h0, dbgState}, 8'h02);
        cyc(1);
        checkIdleOutputs("idle_after_rel");
        chk("idle_state", {6'h0, dbgState}, 8'h00);
        cyc(1);
        checkGrant("fix_ch3", 2'd3);

        // Reset in the middle of a grant
        cyc(1);
        doReset("rst_mid");

        // Rotating priority with all four channels requesting
`ifdef DMA_ROTATING_PRIORITY_EN
        rotExp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        rotExp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        rotatingPri = 1'b1;
        maskWr = 1'b1; maskData = 4'h0; DREQ = 4'b1111;
        cyc(1);
        maskWr = 1'b0;
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            checkGrant($sformatf("rot%0d", i), rotExp[i]);
            if (i < 4) begin
                doSvc(1'b0);
                cyc(2);
            end
        end

        // Terminal count on channel 2: auto-mask when autoInit is clear
        doReset("rst_tc");
        maskWr = 1'b1; maskData = 4'h0; DREQ = 4'b0100;
        cyc(1);
        maskWr = 1'b0;
        cyc(1);
        checkGrant("tc_ch2", 2'd2);
        doSvc(1'b1);
        chk("tc_mask_set", {4'h0, maskReg}, 8'h04);
        cyc(3);
        checkIdleOutputs("tc_no_regrant");
        chk("tc_status", {4'h0, reqStatus}, 8'h04);

        // Same channel with autoInit set keeps its mask bit clear
        autoInit = 4'b0100;
        maskWr = 1'b1; maskData = 4'h0;
        cyc(1);
        maskWr = 1'b0;
        cyc(1);
        checkGrant("ai_ch2", 2'd2);
        doSvc(1'b1);
        chk("ai_mask_clear", {4'h0, maskReg}, 8'h00);
        cyc(2);
        checkGrant("ai_regrant", 2'd2);

        // CPU mask clear in the same cycle as a TC auto-mask: CPU wins
        autoInit = 4'h0;
        maskSingleWr = 1'b1; maskSingleData = 3'b010;
        doSvc(1'b1);
        maskSingleWr = 1'b0;
        chk("cpu_beats_tc", {4'h0, maskReg}, 8'h00);
        cyc(2);
        checkGrant("cpu_regrant", 2'd2);

        // Software request under a fully set mask
        cyc(1);
        doReset("rst_sw");
        swReqWr = 1'b1; swReqData = 3'b111;
        cyc(1);
        swReqWr = 1'b0;
        chk("sw_req", {4'h0, reqReg}, 8'h08);
        chk("sw_status", {4'h0, reqStatus}, 8'h08);
        cyc(1);
        checkGrant("sw_ch3", 2'd3);
        doSvc(1'b1);
        chk("sw_req_clr", {4'h0, reqReg}, 8'h00);
        chk("sw_mask", {4'h0, maskReg}, 8'h0F);
        cyc(3);
        checkIdleOutputs("sw_no_regrant");

        // Write-all and single-bit mask writes in one cycle
        maskWr = 1'b1; maskData = 4'hF;
        maskSingleWr = 1'b1; maskSingleData = 3'b001;
        cyc(1);
        maskWr = 1'b0; maskSingleWr = 1'b0;
        chk("mask_order", {4'h0, maskReg}, 8'h0D);

        // ctrlDisable blocks grants; svcDone in IDLE has no effect
        ctrlDisable = 1'b1;
        swReqWr = 1'b1; swReqData = 3'b100;
        cyc(1);
        swReqWr = 1'b0;
        cyc(2);
        checkIdleOutputs("dis_no_grant");
        doSvc(1'b1);
        chk("idle_svc_req",  {4'h0, reqReg}, 8'h01);
        chk("idle_svc_mask", {4'h0, maskReg}, 8'h0D);
        ctrlDisable = 1'b0;
        cyc(1);
        checkGrant("dis_release_ch0", 2'd0);

        // Active-low DREQ polarity
        cyc(1);
        doReset("rst_pol");
        dreqActiveLow = 1'b1; DREQ = 4'b1110;
        maskWr = 1'b1; maskData = 4'h0;
        cyc(1);
        maskWr = 1'b0;
        chk("pol_status", {4'h0, reqStatus}, 8'h01);
        cyc(1);
        checkGrant("pol_ch0", 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
